// File: rtl/lfsr_pkg.sv
// Shared definitions for the challenge LFSR: FSM states, update-mode codes
// and maximal-length default tap masks.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lfsr_state_t;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

  // Bit i set selects stage i; each mask is a primitive polynomial of that degree.
  function automatic logic [15:0] default_taps(input int width);
    logic [15:0] taps;
    case (width)
      4:       taps = 16'h0009;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_next_state.sv
// Combinational single-step LFSR update, Fibonacci or Galois form.
// Shared with the PUF response scrambler.
module lfsr_next_state
  import lfsr_pkg::*;
#(
  parameter int                 WIDTH = 4,
  parameter logic [WIDTH-1:0]   TAPS  = 4'b1001
) (
  input  logic [WIDTH-1:0] state,
  input  logic             mode,
  output logic [WIDTH-1:0] next_state
);

  logic             fib_fb;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;

  assign fib_fb   = ^(state & TAPS);
  assign fib_next = {state[WIDTH-2:0], fib_fb};

  // Galois: shift left, then fold the outgoing MSB back in at every tap.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_gal
      if (gi == 0) begin : g_lsb
        assign gal_next[gi] = state[WIDTH-1] & TAPS[gi];
      end else begin : g_upper
        assign gal_next[gi] = state[gi-1] ^ (state[WIDTH-1] & TAPS[gi]);
      end
    end
  endgenerate

  assign next_state = (mode == MODE_GAL) ? gal_next : fib_next;

endmodule

// File: rtl/lfsr_seq_gen.sv
// Challenge-word LFSR with seed loading, zero-seed protection and a
// start/done handshake that advances the register a programmed number of steps.
module lfsr_seq_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] TAPS       = 4'b1001,
  parameter logic [WIDTH-1:0] RESET_SEED = 4'b0001,
  parameter int               CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode,
  input  logic             start,
  input  logic [CNT_W-1:0] steps,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             busy,
  output logic             done,
  output logic             lockup
);

  lfsr_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             mode_reg, mode_next;
  logic [WIDTH-1:0] lfsr_reg, lfsr_next;
  logic             done_reg, done_next;
  logic             lockup_reg, lockup_next;

  logic [WIDTH-1:0] lfsr_upd;
  logic [WIDTH-1:0] lfsr_upd_safe;
  logic             seed_zero;

  lfsr_next_state #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_next_state (
    .state      (lfsr_reg),
    .mode       (mode_reg),
    .next_state (lfsr_upd)
  );

  // A non-primitive tap mask can collapse to zero; never let that stick.
  assign lfsr_upd_safe = (lfsr_upd == '0) ? RESET_SEED : lfsr_upd;
  assign seed_zero     = (seed_in == '0);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    mode_next   = mode_reg;
    lfsr_next   = lfsr_reg;
    done_next   = 1'b0;
    lockup_next = lockup_reg;
    if (load) begin
      // Load aborts any run silently, including one sitting in DONE.
      lfsr_next   = seed_zero ? RESET_SEED : seed_in;
      lockup_next = seed_zero;
      state_next  = IDLE;
      cnt_next    = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (steps != '0) begin
              mode_next  = mode;
              cnt_next   = steps;
              state_next = RUN;
            end else begin
              state_next = DONE;
            end
          end
        end
        RUN: begin
          lfsr_next = lfsr_upd_safe;
          cnt_next  = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_next = DONE;
          end
        end
        DONE: begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      mode_reg   <= MODE_FIB;
      lfsr_reg   <= RESET_SEED;
      done_reg   <= 1'b0;
      lockup_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      mode_reg   <= mode_next;
      lfsr_reg   <= lfsr_next;
      done_reg   <= done_next;
      lockup_reg <= lockup_next;
    end
  end

  assign lfsr_out = lfsr_reg;
  assign busy     = (state_reg == RUN);
  assign done     = done_reg;
  assign lockup   = lockup_reg;

endmodule
